alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width (legal range 8..64).
REQ-002 SHALL have parameter FLAG_W, default 4, flag vector width (fixed {C,N,V,Z} = bits [3:0]).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1: request handshake.
REQ-006 SHALL have ports func input 4 (opcode), op0 input WIDTH, op1 input WIDTH, flag_in input 4, flag_en input 1.
REQ-007 SHALL have ports out_valid output 1 and out_ready input 1: result handshake.
REQ-008 SHALL have ports q output WIDTH (result) and flag_out output 4 (registered flags {C,N,V,Z}).

Function
REQ-009 SHALL accept a request when in_valid && in_ready; operands, func, flag_in, flag_en captured that edge.
REQ-010 SHALL implement FSM IDLE -> (accept, single-cycle op) HOLD; IDLE -> (accept, MUL) BUSY -> (WIDTH iterations done) HOLD; HOLD -> (out_ready) IDLE.
REQ-011 SHALL drive in_ready=1 only in IDLE, out_valid=1 only in HOLD; q and flag_out stable throughout HOLD.
REQ-012 SHALL give single-cycle ops latency 1: out_valid rises the edge after acceptance.
REQ-013 SHALL decode func: 0 ADD, 1 ADC (+flag_in[3]), 2 SUB, 3 LSL, 4 LSR, 5 AND, 6 OR, 7 XOR, 8 MOV (q=op1), 9 AGEN (op0+op1, flags never updated), A MUL, B BEQ, C BNE, D BLT, E BGT, F CMP.
REQ-014 SHALL compute ADD/ADC/SUB/CMP in WIDTH+1 bits; SUB/CMP = op0 + ~op1 + 1; C = bit WIDTH of that sum.
REQ-015 SHALL derive N, Z, V from the new result of the same operation (never the previous q); V = operands same sign (op1 inverted for SUB/CMP) and result sign differs.
REQ-016 SHALL for LSL/LSR use shift amount op1; amount 0 -> q=op0, C=0; 1..WIDTH -> C = last bit shifted out; amount>WIDTH -> q=0, C=0; V=0.
REQ-017 SHALL set C=0, V=0 for AND/OR/XOR/MOV.
REQ-018 SHALL update flag_out only when flag_en=1 for arithmetic/logic/shift/MUL ops; CMP always updates flags and leaves q unchanged.
REQ-019 SHALL for branches output q = op0 if condition true else op1 (next PC); BEQ Z=1, BNE Z=0, BLT N^V=1, BGT N^V=0 && Z=0, conditions read from flag_in; flags unchanged.
REQ-020 SHALL treat MUL as unsigned shift-add, one bit per cycle, WIDTH cycles in BUSY; q = low WIDTH bits; C = 1 if high half nonzero; N, Z from q; V=0.
REQ-021 SHALL ignore in_valid while not in IDLE; out_ready outside HOLD has no effect.

Reset
REQ-022 SHALL on rst asynchronously force state IDLE, q=0, flag_out=4'b0000, out_valid=0, in_ready=1, multiply counter and accumulator 0.
REQ-023 SHALL abandon any in-flight MUL or held result on reset mid-operation; no out_valid follows.

Configuration
REQ-024 SHALL compile MUL and BUSY state only when macro ALU_SEQ_MUL_EN is defined.
REQ-025 SHALL without ALU_SEQ_MUL_EN treat func A as MOV-less NOP: latency 1, q=0, flags unchanged.

Structure
REQ-026 SHALL place opcode localparams, flag bit indices and FSM state encodings in shared package alu_pkg.
REQ-027 SHALL implement the iterative multiplier as sub-module alu_mul_iter (start, busy, done, product).

Verification
REQ-028 ADD 16'h7FFF+16'h0001, flag_en=1 -> q=16'h8000, flags C0 N1 V1 Z0, out_valid next cycle.
REQ-029 SUB 16'h0005-16'h0005 -> q=0, flags C1 N0 V0 Z1; same with flag_en=0 -> flag_out unchanged.
REQ-030 LSL 16'h8001 by 1 -> q=16'h0002, C=1; LSR by 17 -> q=0, C=0.
REQ-031 BEQ op0=16'h0040, op1=16'h0012, flag_in Z=1 -> q=16'h0040; Z=0 -> q=16'h0012.
REQ-032 MUL (macro on) 16'h0100*16'h0100 -> out_valid after 17 cycles, q=0, C=1, Z=1; in_valid during BUSY ignored.
REQ-033 out_ready held 0 for 5 cycles -> q/out_valid stable; rst asserted mid-MUL -> IDLE, q=0, no out_valid.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg -- shared definitions for the alu_seq sequential ALU.
//   * opcode values for the 4-bit func field
//   * bit positions inside the {C,N,V,Z} flag vector
//   * FSM state encoding
// Optional feature macro: ALU_SEQ_MUL_EN (adds the BUSY state used by MUL).
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADC  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_LSL  = 4'h3;
  localparam logic [3:0] OP_LSR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_MOV  = 4'h8;
  localparam logic [3:0] OP_AGEN = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_BNE  = 4'hC;
  localparam logic [3:0] OP_BLT  = 4'hD;
  localparam logic [3:0] OP_BGT  = 4'hE;
  localparam logic [3:0] OP_CMP  = 4'hF;

  // Flag vector layout is {C,N,V,Z} on bits [3:0]
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef ALU_SEQ_MUL_EN
    ST_BUSY = 2'd1,
`endif
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if -- request/result bus of the alu_seq ALU.
//   request : in_valid, in_ready, func, op0, op1, flag_in, flag_en
//   result  : out_valid, out_ready, q, flag_out ({C,N,V,Z})
// modport master : the requester (drives operands, consumes results)
// modport slave  : the ALU
// ---------------------------------------------------------------------------
interface alu_seq_if #(
  parameter int WIDTH  = 16,
  parameter int FLAG_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        func;
  logic [WIDTH-1:0]  op0;
  logic [WIDTH-1:0]  op1;
  logic [FLAG_W-1:0] flag_in;
  logic              flag_en;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  q;
  logic [FLAG_W-1:0] flag_out;

  modport master (
    output in_valid, func, op0, op1, flag_in, flag_en, out_ready,
    input  in_ready, out_valid, q, flag_out
  );

  modport slave (
    input  in_valid, func, op0, op1, flag_in, flag_en, out_ready,
    output in_ready, out_valid, q, flag_out
  );
endinterface

// File: rtl/alu_mul_iter.sv
// ---------------------------------------------------------------------------
// alu_mul_iter -- unsigned shift-add multiplier, one multiplier bit per cycle.
// Only built when ALU_SEQ_MUL_EN is defined.
//   clk, rst : clock, asynchronous active-high reset
//   start    : load operands a/b and begin (ignored while busy)
//   busy     : iterating (WIDTH cycles after start)
//   done     : one-cycle pulse once product is final
//   product  : 2*WIDTH-bit result, valid while done is high and afterwards
// ---------------------------------------------------------------------------
`ifdef ALU_SEQ_MUL_EN
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic               busy_reg;
  logic               done_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start && !busy_reg) begin
        cnt_reg    <= '0;
        acc_reg    <= '0;
        mcand_reg  <= {{WIDTH{1'b0}}, a};
        mplier_reg <= b;
        busy_reg   <= 1'b1;
      end else if (busy_reg) begin
        // Add the shifted multiplicand for each set multiplier bit, LSB first
        if (mplier_reg[0]) begin
          acc_reg <= acc_reg + mcand_reg;
        end
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        cnt_reg    <= cnt_reg + 1'b1;
        if (cnt_reg == CW'(WIDTH - 1)) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign product = acc_reg;
endmodule
`endif

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- sequential ALU with valid/ready request and result handshakes.
//   clk : clock, all state on the rising edge
//   rst : asynchronous active-high reset
//   bus : alu_seq_if.slave (in_valid/in_ready, func, op0, op1, flag_in,
//         flag_en, out_valid/out_ready, q, flag_out {C,N,V,Z})
// Single-cycle ops complete on the accepting edge (IDLE -> HOLD). The result
// stays in HOLD until out_ready. With ALU_SEQ_MUL_EN defined, func A runs the
// iterative multiplier through BUSY; without it func A is a NOP (q=0).
// ---------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int FLAG_W = 4
) (
  input logic     clk,
  input logic     rst,
  alu_seq_if.slave bus
);

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  q_reg, q_next;
  logic [FLAG_W-1:0] flag_reg, flag_next;

  // Combinational result of the request currently on the bus
  logic [WIDTH-1:0]  addend;
  logic              cin;
  logic [WIDTH:0]    sum;
  logic [WIDTH:0]    shl_ext;
  logic [WIDTH:0]    shr_ext;
  logic [WIDTH-1:0]  res;
  logic              res_c, res_v, take;
  logic [WIDTH-1:0]  alu_q;
  logic [FLAG_W-1:0] alu_flags;
  logic              load_q, load_flags;

  always_comb begin
    addend     = bus.op1;
    cin        = 1'b0;
    res        = '0;
    res_c      = 1'b0;
    res_v      = 1'b0;
    take       = 1'b0;
    load_q     = 1'b1;
    load_flags = bus.flag_en;

    if (bus.func == OP_SUB || bus.func == OP_CMP) begin
      addend = ~bus.op1;
      cin    = 1'b1;
    end else if (bus.func == OP_ADC) begin
      cin = bus.flag_in[FLAG_C];
    end
    sum = {1'b0, bus.op0} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};

    // Shifts run one bit wider so the last bit shifted out lands in the
    // extra bit; amounts past WIDTH naturally yield zero result and C=0.
    shl_ext = {1'b0, bus.op0} << bus.op1;
    shr_ext = {bus.op0, 1'b0} >> bus.op1;

    case (bus.func)
      OP_ADD, OP_ADC, OP_SUB, OP_CMP: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (bus.op0[WIDTH-1] == addend[WIDTH-1]) &&
                (sum[WIDTH-1] != bus.op0[WIDTH-1]);
        if (bus.func == OP_CMP) begin
          load_q     = 1'b0;
          load_flags = 1'b1;
        end
      end
      OP_LSL: begin
        res   = shl_ext[WIDTH-1:0];
        res_c = shl_ext[WIDTH];
      end
      OP_LSR: begin
        res   = shr_ext[WIDTH:1];
        res_c = shr_ext[0];
      end
      OP_AND: res = bus.op0 & bus.op1;
      OP_OR:  res = bus.op0 | bus.op1;
      OP_XOR: res = bus.op0 ^ bus.op1;
      OP_MOV: res = bus.op1;
      OP_AGEN: begin
        res        = sum[WIDTH-1:0];
        load_flags = 1'b0;
      end
      OP_MUL: begin
        res        = '0;
        load_flags = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        load_q     = 1'b0;   // result arrives later from the multiplier
`endif
      end
      default: begin
        // Branches: next PC is op0 when taken, op1 otherwise
        case (bus.func)
          OP_BEQ:  take = bus.flag_in[FLAG_Z];
          OP_BNE:  take = !bus.flag_in[FLAG_Z];
          OP_BLT:  take = bus.flag_in[FLAG_N] ^ bus.flag_in[FLAG_V];
          default: take = !(bus.flag_in[FLAG_N] ^ bus.flag_in[FLAG_V]) &&
                          !bus.flag_in[FLAG_Z];
        endcase
        res        = take ? bus.op0 : bus.op1;
        load_flags = 1'b0;
      end
    endcase

    alu_q             = res;
    alu_flags         = '0;
    alu_flags[FLAG_C] = res_c;
    alu_flags[FLAG_N] = res[WIDTH-1];
    alu_flags[FLAG_V] = res_v;
    alu_flags[FLAG_Z] = (res == '0);
  end

`ifdef ALU_SEQ_MUL_EN
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [FLAG_W-1:0]  mul_flags;
  logic               flag_en_reg;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (bus.op0),
    .b       (bus.op1),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_C] = |mul_product[2*WIDTH-1:WIDTH];
    mul_flags[FLAG_N] = mul_product[WIDTH-1];
    mul_flags[FLAG_Z] = (mul_product[WIDTH-1:0] == '0);
  end

  // flag_en belongs to the request, so hold it until the product is ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_en_reg <= 1'b0;
    end else if (mul_start) begin
      flag_en_reg <= bus.flag_en;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      q_reg     <= '0;
      flag_reg  <= '0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      flag_reg  <= flag_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    flag_next  = flag_reg;
`ifdef ALU_SEQ_MUL_EN
    mul_start  = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_next = ST_HOLD;
          if (load_q)     q_next    = alu_q;
          if (load_flags) flag_next = alu_flags;
`ifdef ALU_SEQ_MUL_EN
          if (bus.func == OP_MUL) begin
            state_next = ST_BUSY;
            mul_start  = 1'b1;
          end
`endif
        end
      end
`ifdef ALU_SEQ_MUL_EN
      ST_BUSY: begin
        // done is a pulse issued after busy drops
        if (mul_done && !mul_busy) begin
          state_next = ST_HOLD;
          q_next     = mul_product[WIDTH-1:0];
          if (flag_en_reg) flag_next = mul_flags;
        end
      end
`endif
      ST_HOLD: begin
        if (bus.out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_reg == ST_IDLE);
  assign bus.out_valid = (state_reg == ST_HOLD);
  assign bus.q         = q_reg;
  assign bus.flag_out  = flag_reg;

endmodule
